// File: rtl/mac_sequencer_if.sv
// Bus bundle between mac_sequencer and its environment: control handshake,
// operand memory read ports, external MAC and result write port.
interface mac_sequencer_if #(
    parameter int unsigned AW = 4
) ();
    logic                 start;
    logic                 busy;
    logic                 done;

    logic [AW-1:0]        a_addr;
    logic [AW-1:0]        b_addr;
    logic signed [7:0]    a_data;
    logic signed [7:0]    b_data;

    logic signed [7:0]    mplier;
    logic signed [7:0]    mcand;
    logic                 mac_clr;
    logic                 mac_en;
    logic signed [15:0]   mac_dout;

    logic [AW-1:0]        c_addr;
    logic signed [15:0]   c_data;
    logic                 c_we;

    modport master (
        input  start,
        input  a_data,
        input  b_data,
        input  mac_dout,
        output busy,
        output done,
        output a_addr,
        output b_addr,
        output mplier,
        output mcand,
        output mac_clr,
        output mac_en,
        output c_addr,
        output c_data,
        output c_we
    );

    modport slave (
        output start,
        output a_data,
        output b_data,
        output mac_dout,
        input  busy,
        input  done,
        input  a_addr,
        input  b_addr,
        input  mplier,
        input  mcand,
        input  mac_clr,
        input  mac_en,
        input  c_addr,
        input  c_data,
        input  c_we
    );
endinterface

// File: rtl/mac_sequencer.sv
// Sequences an N x N matrix product C = A x B through an external MAC, one
// result element every N+2 cycles (N issue cycles, one drain, one write).
module mac_sequencer #(
    parameter int unsigned N  = 4,
    parameter int unsigned AW = 4
) (
    input  logic              clk,
    input  logic              aclr,
    mac_sequencer_if.master   bus
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LastIdx = CW'(N - 1);

    if (N * N > (1 << AW)) begin : g_param_check
        $error("mac_sequencer: N*N must fit in the AW-bit address space");
    end

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StDrain,
        StWrite,
        StFin
    } state_e;

    state_e        r_state;
    state_e        w_state_nxt;
    logic [CW-1:0] r_i;
    logic [CW-1:0] r_j;
    logic [CW-1:0] r_k;
    logic [CW-1:0] w_i_nxt;
    logic [CW-1:0] w_j_nxt;
    logic [CW-1:0] w_k_nxt;

    // Operand pair from the previous ISSUE cycle is on a_data/b_data now.
    logic          r_pair_vld;
    logic          r_pair_first;

    logic          w_issue;
    logic          w_write;

    always_ff @(posedge clk) begin
        if (aclr) begin
            r_state      <= StIdle;
            r_i          <= '0;
            r_j          <= '0;
            r_k          <= '0;
            r_pair_vld   <= 1'b0;
            r_pair_first <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_i          <= w_i_nxt;
            r_j          <= w_j_nxt;
            r_k          <= w_k_nxt;
            r_pair_vld   <= w_issue;
            r_pair_first <= w_issue && (r_k == '0);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state_nxt = StIssue;
                    w_i_nxt     = '0;
                    w_j_nxt     = '0;
                    w_k_nxt     = '0;
                end
            end
            StIssue: begin
                if (r_k == LastIdx) begin
                    w_state_nxt = StDrain;
                    w_k_nxt     = '0;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            StDrain: begin
                w_state_nxt = StWrite;
            end
            StWrite: begin
                w_k_nxt = '0;
                if (r_j == LastIdx) begin
                    w_j_nxt = '0;
                    if (r_i == LastIdx) begin
                        w_state_nxt = StFin;
                    end else begin
                        w_i_nxt     = r_i + 1'b1;
                        w_state_nxt = StIssue;
                    end
                end else begin
                    w_j_nxt     = r_j + 1'b1;
                    w_state_nxt = StIssue;
                end
            end
            StFin: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign w_issue = (r_state == StIssue);
    assign w_write = (r_state == StWrite);

    always_comb begin
        bus.busy    = (r_state == StIssue) || (r_state == StDrain) || (r_state == StWrite);
        bus.done    = (r_state == StFin);

        bus.a_addr  = '0;
        bus.b_addr  = '0;
        if (w_issue) begin
            bus.a_addr = AW'(32'(r_i) * N + 32'(r_k));
            bus.b_addr = AW'(32'(r_k) * N + 32'(r_j));
        end

        bus.mplier  = r_pair_vld ? bus.a_data : '0;
        bus.mcand   = r_pair_vld ? bus.b_data : '0;
        bus.mac_en  = r_pair_vld;
        bus.mac_clr = r_pair_first;

        // MAC output is already registered; pass it straight through, wrap and all.
        bus.c_we    = w_write;
        bus.c_addr  = w_write ? AW'(32'(r_i) * N + 32'(r_j)) : '0;
        bus.c_data  = w_write ? bus.mac_dout : '0;
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: operand memories and a MAC model around the
// DUT, table of matrix vectors plus abort/restart corner sequences.
module tb_mac_sequencer;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 4;
    localparam int unsigned NE = N * N;

    typedef struct {
        logic [NE-1:0][7:0]  a;
        logic [NE-1:0][7:0]  b;
        logic [NE-1:0][15:0] c;
    } vec_t;

    logic clk = 1'b0;
    logic aclr;

    always #5 clk = ~clk;

    mac_sequencer_if #(.AW(AW)) bus ();

    mac_sequencer #(
        .N  (N),
        .AW (AW)
    ) dut (
        .clk  (clk),
        .aclr (aclr),
        .bus  (bus)
    );

    // Environment: 1-cycle-latency operand memories and the external MAC.
    logic signed [7:0]  mem_a [NE];
    logic signed [7:0]  mem_b [NE];
    logic signed [15:0] acc;
    logic signed [15:0] ext_p;
    logic signed [15:0] ext_c;
    logic signed [15:0] prod;

    always_comb begin
        ext_p = bus.mplier;
        ext_c = bus.mcand;
        prod  = ext_p * ext_c;
    end

    always @(posedge clk) begin
        bus.a_data <= mem_a[bus.a_addr];
        bus.b_data <= mem_b[bus.b_addr];
        if (bus.mac_en) acc <= bus.mac_clr ? prod : acc + prod;
    end

    assign bus.mac_dout = acc;

    // Monitor, sampled on the falling edge.
    int          cyc = 0;
    int          n_we, n_done, n_clr, n_viol, n_order, n_busy;
    int          first_busy, done_at;
    bit          seen_busy;
    logic [15:0] c_mem [NE];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.busy === 1'b1) begin
            n_busy = n_busy + 1;
            if (!seen_busy) begin
                seen_busy  = 1'b1;
                first_busy = cyc;
            end
        end
        if (bus.c_we === 1'b1) begin
            if (int'(bus.c_addr) != n_we) n_order = n_order + 1;
            c_mem[bus.c_addr] = bus.c_data;
            n_we = n_we + 1;
        end
        if (bus.done === 1'b1) begin
            n_done  = n_done + 1;
            done_at = cyc;
        end
        if (bus.mac_clr === 1'b1) n_clr = n_clr + 1;
        if ((bus.mac_en !== 1'b1 && (bus.mplier != 0 || bus.mcand != 0 || bus.mac_clr)) ||
            (bus.c_we !== 1'b1 && (bus.c_addr != 0 || bus.c_data != 0)) ||
            (bus.done === 1'b1 && bus.busy === 1'b1))
            n_viol = n_viol + 1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        n_we = 0; n_done = 0; n_clr = 0; n_viol = 0; n_order = 0; n_busy = 0;
        first_busy = 0; done_at = 0; seen_busy = 1'b0;
        for (int e = 0; e < NE; e++) c_mem[e] = 16'hDEAD;
    endtask

    task automatic load(input vec_t v);
        for (int e = 0; e < NE; e++) begin
            mem_a[e] = v.a[e];
            mem_b[e] = v.b[e];
        end
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < limit; t++) begin
            tick();
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic verify_run(input vec_t v, input string tag);
        bit ok;
        wait_done(400, ok);
        check({tag, " done seen"}, 32'(ok), 32'd1);
        tick();
        for (int e = 0; e < NE; e++)
            check($sformatf("%s c[%0d]", tag, e), {16'h0, c_mem[e]}, {16'h0, v.c[e]});
        check({tag, " c_we count"}, n_we, 16);
        check({tag, " c_addr order"}, n_order, 0);
        check({tag, " done count"}, n_done, 1);
        check({tag, " issue-to-done"}, done_at - first_busy, 96);
        check({tag, " busy cycles"}, n_busy, 96);
        check({tag, " mac_clr count"}, n_clr, 16);
        check({tag, " idle outputs"}, n_viol, 0);
    endtask

    vec_t vecs [4];
    int   wr_seen;

    initial begin
        aclr      = 1'b1;
        bus.start = 1'b0;
        acc       = '0;
        for (int e = 0; e < NE; e++) begin
            mem_a[e] = '0;
            mem_b[e] = '0;
        end
        clear_stats();

        // Identity x ramp; all -128 (wraps to 0); ones x -1; ramp x 2I.
        for (int e = 0; e < NE; e++) begin
            vecs[0].a[e] = (e / N == e % N) ? 8'd1 : 8'd0;
            vecs[0].b[e] = 8'(e);
            vecs[0].c[e] = 16'(e);
            vecs[1].a[e] = 8'h80;
            vecs[1].b[e] = 8'h80;
            vecs[1].c[e] = 16'h0000;
            vecs[2].a[e] = 8'h01;
            vecs[2].b[e] = 8'hFF;
            vecs[2].c[e] = 16'hFFFC;
            vecs[3].a[e] = 8'(e - 8);
            vecs[3].b[e] = (e / N == e % N) ? 8'd2 : 8'd0;
            vecs[3].c[e] = 16'(2 * (e - 8));
        end

        repeat (3) tick();
        check("reset busy", 32'(bus.busy), 0);
        check("reset done", 32'(bus.done), 0);
        check("reset addr/operands", 32'({bus.a_addr, bus.b_addr, bus.mplier, bus.mcand}), 0);
        check("reset mac/write", 32'({bus.mac_clr, bus.mac_en, bus.c_we, bus.c_addr, bus.c_data}), 0);
        aclr = 1'b0;
        tick();

        for (int v = 0; v < 4; v++) begin
            load(vecs[v]);
            clear_stats();
            start_pulse();
            verify_run(vecs[v], $sformatf("vec%0d", v));
            repeat (2) tick();
        end

        // Second start 10 cycles into a run is ignored.
        load(vecs[0]);
        clear_stats();
        start_pulse();
        repeat (9) tick();
        start_pulse();
        verify_run(vecs[0], "restart");
        repeat (30) tick();
        check("restart no rerun busy", n_busy, 96);
        check("restart no rerun c_we", n_we, 16);

        // aclr during the 3rd WRITE aborts the run.
        load(vecs[2]);
        clear_stats();
        start_pulse();
        wr_seen = 0;
        for (int t = 0; t < 200 && wr_seen < 3; t++) begin
            tick();
            if (bus.c_we === 1'b1) wr_seen = wr_seen + 1;
        end
        check("abort reached 3rd write", wr_seen, 3);
        aclr = 1'b1;
        tick();
        check("abort busy", 32'(bus.busy), 0);
        check("abort c_we", 32'(bus.c_we), 0);
        tick();
        aclr = 1'b0;
        repeat (100) tick();
        check("abort c_we count", n_we, 3);
        check("abort done count", n_done, 0);
        check("abort partial c[2]", {16'h0, c_mem[2]}, 32'h0000_FFFC);
        check("abort untouched c[3]", {16'h0, c_mem[3]}, 32'h0000_DEAD);
        check("abort idle outputs", n_viol, 0);
        clear_stats();
        start_pulse();
        verify_run(vecs[2], "after abort");

        // aclr overrides a simultaneous start.
        tick();
        aclr      = 1'b1;
        bus.start = 1'b1;
        tick();
        check("aclr+start busy", 32'(bus.busy), 0);
        aclr      = 1'b0;
        bus.start = 1'b0;
        repeat (3) tick();
        check("aclr+start stays idle", 32'(bus.busy), 0);

        // start accepted in the first IDLE cycle after aclr drops.
        load(vecs[3]);
        aclr = 1'b1;
        tick();
        clear_stats();
        aclr = 1'b0;
        start_pulse();
        check("first idle start busy", 32'(bus.busy), 1);
        verify_run(vecs[3], "post-aclr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
